// File: rtl/fwd_hazard_if.sv
// Bundle between the ID/EX pipeline control and the forwarding/hazard unit.
// The pipeline side is master, the unit is slave.
interface fwd_hazard_if #(
  parameter int DATA_W = 33,
  parameter int CNT_W  = 32
);
  logic              mem_stall;
  logic              clr_cnt;
  logic [4:0]        ifid_rs;
  logic [4:0]        ifid_rt;
  logic              ifid_is_branch;
  logic              ifid_uses_rt;
  logic [4:0]        idex_rs;
  logic [4:0]        idex_rt;
  logic [4:0]        idex_rd;
  logic              idex_reg_write;
  logic              idex_mem_read;
  logic [4:0]        exmem_rd;
  logic              exmem_reg_write;
  logic              exmem_mem_read;
  logic [4:0]        memwb_rd;
  logic              memwb_reg_write;
  logic [DATA_W-1:0] exmem_data;
  logic [DATA_W-1:0] memwb_data;
  logic [DATA_W-1:0] reg_data1;
  logic [DATA_W-1:0] reg_data2;
  logic [DATA_W-1:0] idex_data1;
  logic [DATA_W-1:0] idex_data2;
  logic [DATA_W-1:0] alu_data1;
  logic [DATA_W-1:0] alu_data2;
  logic [DATA_W-1:0] branch_data1;
  logic [DATA_W-1:0] branch_data2;
  logic              pc_hold;
  logic              idex_bubble;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  hazard_events;

  modport master (
    output mem_stall, clr_cnt,
    output ifid_rs, ifid_rt, ifid_is_branch, ifid_uses_rt,
    output idex_rs, idex_rt, idex_rd,
    output idex_reg_write, idex_mem_read,
    output exmem_rd, exmem_reg_write, exmem_mem_read,
    output memwb_rd, memwb_reg_write,
    output exmem_data, memwb_data,
    output reg_data1, reg_data2, idex_data1, idex_data2,
    input  alu_data1, alu_data2, branch_data1, branch_data2,
    input  pc_hold, idex_bubble, stall_cycles, hazard_events
  );

  modport slave (
    input  mem_stall, clr_cnt,
    input  ifid_rs, ifid_rt, ifid_is_branch, ifid_uses_rt,
    input  idex_rs, idex_rt, idex_rd,
    input  idex_reg_write, idex_mem_read,
    input  exmem_rd, exmem_reg_write, exmem_mem_read,
    input  memwb_rd, memwb_reg_write,
    input  exmem_data, memwb_data,
    input  reg_data1, reg_data2, idex_data1, idex_data2,
    output alu_data1, alu_data2, branch_data1, branch_data2,
    output pc_hold, idex_bubble, stall_cycles, hazard_events
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Combined EX/branch operand forwarding with writeback history,
// stall generation and saturating hazard counters.
module fwd_hazard_unit #(
  parameter int DATA_W     = 33,
  parameter int HIST_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input logic         clk,
  input logic         rst_n,
  fwd_hazard_if.slave bus
);
  typedef logic [DATA_W-1:0] word_t;
  typedef enum logic [1:0] {RUN, HAZ, FREEZE} state_t;

  state_t state, stateNx;
  logic   prevRun, prevRunNx, newEvent;
  logic   hazard, holdNow, push;
  logic   exOk, wbOk;
  logic [4:0] exRd, wbRd;
  word_t  exD, wbD;

  logic [HIST_DEPTH-1:0]             histV;
  logic [HIST_DEPTH-1:0][4:0]        histRd;
  logic [HIST_DEPTH-1:0][DATA_W-1:0] histData;
  logic [CNT_W-1:0] stallCnt, evtCnt;

  assign exOk = bus.exmem_reg_write && !bus.exmem_mem_read;
  assign wbOk = bus.memwb_reg_write;
  assign exRd = bus.exmem_rd;
  assign wbRd = bus.memwb_rd;
  assign exD  = bus.exmem_data;
  assign wbD  = bus.memwb_data;

  // Oldest history first so younger entries and pipeline regs override.
  function automatic word_t pick(
    input logic [4:0] r,
    input word_t      dflt
  );
    word_t v;
    v = dflt;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (histV[i] && histRd[i] == r) v = histData[i];
    end
    if (wbOk && wbRd != 5'd0 && wbRd == r) v = wbD;
    if (exOk && exRd != 5'd0 && exRd == r) v = exD;
    return v;
  endfunction

  function automatic logic dep(input logic [4:0] r);
    return (r != 5'd0) &&
      ((r == bus.ifid_rs) ||
       (bus.ifid_uses_rt && r == bus.ifid_rt));
  endfunction

  always_comb begin
    bus.alu_data1    = pick(bus.idex_rs, bus.idex_data1);
    bus.alu_data2    = pick(bus.idex_rt, bus.idex_data2);
    bus.branch_data1 = bus.reg_data1;
    bus.branch_data2 = bus.reg_data2;
    if (bus.ifid_is_branch) begin
      bus.branch_data1 = pick(bus.ifid_rs, bus.reg_data1);
      bus.branch_data2 = pick(bus.ifid_rt, bus.reg_data2);
    end
  end

  assign hazard =
    (bus.idex_mem_read && dep(bus.idex_rd)) ||
    (bus.ifid_is_branch && bus.idex_reg_write &&
     dep(bus.idex_rd)) ||
    (bus.ifid_is_branch && bus.exmem_mem_read &&
     bus.exmem_reg_write && dep(bus.exmem_rd));

  assign holdNow = hazard && !bus.mem_stall && rst_n;
  assign push = bus.memwb_reg_write &&
                bus.memwb_rd != 5'd0 && !bus.mem_stall;

  assign bus.pc_hold       = holdNow;
  assign bus.idex_bubble   = holdNow;
  assign bus.stall_cycles  = stallCnt;
  assign bus.hazard_events = evtCnt;

  always_comb begin
    stateNx   = state;
    prevRunNx = prevRun;
    newEvent  = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.mem_stall) begin
          stateNx   = FREEZE;
          prevRunNx = 1'b1;
        end else if (hazard) begin
          stateNx  = HAZ;
          newEvent = 1'b1;
        end
      end
      HAZ: begin
        if (bus.mem_stall) begin
          stateNx   = FREEZE;
          prevRunNx = 1'b0;
        end else if (!hazard) begin
          stateNx = RUN;
        end
      end
      FREEZE: begin
        if (!bus.mem_stall) begin
          if (hazard) begin
            stateNx  = HAZ;
            newEvent = prevRun;
          end else begin
            stateNx = RUN;
          end
        end
      end
      default: stateNx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      prevRun  <= 1'b1;
      histV    <= '0;
      stallCnt <= '0;
      evtCnt   <= '0;
    end else begin
      state   <= stateNx;
      prevRun <= prevRunNx;
      if (push) begin
        for (int i = HIST_DEPTH - 1; i >= 1; i--)
          histV[i] <= histV[i-1];
        histV[0] <= 1'b1;
      end
      if (bus.clr_cnt) begin
        stallCnt <= '0;
        evtCnt   <= '0;
      end else begin
        if (holdNow && stallCnt != '1)
          stallCnt <= stallCnt + CNT_W'(1);
        if (newEvent && evtCnt != '1)
          evtCnt <= evtCnt + CNT_W'(1);
      end
    end
  end

  // Payload needs no reset; validity is tracked by histV.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = HIST_DEPTH - 1; i >= 1; i--) begin
        histRd[i]   <= histRd[i-1];
        histData[i] <= histData[i-1];
      end
      histRd[0]   <= bus.memwb_rd;
      histData[0] <= bus.memwb_data;
    end
  end
endmodule
